twos_comp_frame_acc: RTL

//  - Downstream consumer of the sign-magnitude-to-2's-complement stage: takes its IN_W-bit
//    2's-complement words over a valid/ready handshake.
//  - Sums exactly FRAME_LEN accepted words into a signed ACC_W-bit frame total.
//  - Presents the total with an overflow flag over a second valid/ready handshake.
//  - Feeds downstream result logic / display stages.

---
 rtl/twos_comp_pkg.sv | 13 +
 rtl/tc_sat_adder.sv | 20 ++
 rtl/twos_comp_frame_acc.sv | 66 ++++++
 3 files changed

// File: rtl/twos_comp_pkg.sv
// twos_comp_pkg: shared state encoding, sign extension and signed range helpers.
package twos_comp_pkg;
    typedef enum logic {ST_ACC = 1'b0, ST_OUT = 1'b1} state_t;
    function automatic logic [63:0] sext(input logic [63:0] v, input int w);
        return 64'($signed(v << (64 - w)) >>> (64 - w));
    endfunction
    function automatic logic [63:0] acc_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction
    function automatic logic [63:0] acc_min(input int w);
        return ~acc_max(w);
    endfunction
endpackage

// File: rtl/tc_sat_adder.sv
// tc_sat_adder: signed add with overflow detect; clamps when TC_ACC_SATURATE_EN is defined.
module tc_sat_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);
    logic [W-1:0] raw;
    always_comb begin
        raw = a + b;
        ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
`ifdef TC_ACC_SATURATE_EN
        sum = ovf ? (a[W-1] ? W'(twos_comp_pkg::acc_min(W)) : W'(twos_comp_pkg::acc_max(W))) : raw;
`else
        sum = raw;
`endif
    end
endmodule

// File: rtl/twos_comp_frame_acc.sv
// twos_comp_frame_acc: sums FRAME_LEN signed words per frame and hands out the total with a
// sticky overflow flag; define TC_ACC_SATURATE_EN to clamp instead of wrap.
module twos_comp_frame_acc
    import twos_comp_pkg::*;
#(
    parameter int IN_W      = 4,
    parameter int ACC_W     = 8,
    parameter int FRAME_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf
);
    localparam int CW = $clog2(FRAME_LEN) + 1;
    state_t          state;
    logic [CW-1:0]   count;
    logic [ACC_W-1:0] acc, sum, addend;
    logic            ovf_r, ovf;
    assign addend   = ACC_W'(sext(64'(in_data), IN_W));
    assign in_ready = (state == ST_ACC);
    tc_sat_adder #(.W(ACC_W)) u_add (.a(acc), .b(addend), .sum(sum), .ovf(ovf));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_ACC;
            count     <= '0;
            acc       <= '0;
            ovf_r     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (clr) begin
            state     <= ST_ACC;
            count     <= '0;
            acc       <= '0;
            ovf_r     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (state == ST_ACC) begin
            if (in_valid && in_ready) begin
                acc   <= sum;
                count <= count + 1'b1;
                ovf_r <= ovf_r | ovf;
                if (count == CW'(FRAME_LEN - 1)) begin
                    out_data  <= sum;
                    out_ovf   <= ovf_r | ovf;
                    out_valid <= 1'b1;
                    state     <= ST_OUT;
                end
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            count     <= '0;
            ovf_r     <= 1'b0;
            state     <= ST_ACC;
        end
    end
endmodule
